// File: rtl/example_alu_pkg.sv
// Shared opcodes and FSM state encoding for the sequential example ALU.
// Imported by example_alu_seq and example_shift_mul.
package example_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_LT  = 3'd3;
  localparam logic [2:0] OP_GT  = 3'd4;
  localparam logic [2:0] OP_EQ  = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd6;
  localparam logic [2:0] OP_MIN = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/example_shift_mul.sv
// Iterative shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports: clk, rst, start, a, b in; done strobe and product out.
module example_shift_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import example_alu_pkg::*;

  localparam int OUT_W = 2 * WIDTH;
  localparam int CW    = $clog2(WIDTH + 1);

  logic [OUT_W-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [OUT_W-1:0] prod;
  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] prod_nxt;

  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  // done and product describe the step taken on this edge,
  // so the top can register the final sum as cnt goes 1->0.
  assign done    = (cnt == CW'(1));
  assign product = prod_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= CW'(WIDTH);
    end else if (cnt != '0) begin
      prod   <= prod_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/example_alu_seq.sv
// Registered unsigned ALU/comparator with valid/ready input and multi-cycle MUL.
// Ports: clk, rst, in_valid/in_ready, opc, a, b in; c, zero, out_valid out.
module example_alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         opc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] c,
  output logic               zero,
  output logic               out_valid
);
  import example_alu_pkg::*;

  localparam int OUT_W = 2 * WIDTH;

  state_t           state, state_n;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [OUT_W-1:0] mul_p;
  logic [OUT_W-1:0] ae, be;
  logic [OUT_W-1:0] alu_res;
  logic [OUT_W-1:0] res_nxt;
  logic             res_load;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign ae       = {{WIDTH{1'b0}}, a};
  assign be       = {{WIDTH{1'b0}}, b};

  example_shift_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_p)
  );

  always_comb begin
    alu_res = '0;
    unique case (1'b1)
      (opc == OP_ADD): alu_res = ae + be;
      (opc == OP_SUB): alu_res = ae - be;
      (opc == OP_MUL): alu_res = '0;
      (opc == OP_LT):  alu_res = {{(OUT_W-1){1'b0}}, a < b};
      (opc == OP_GT):  alu_res = {{(OUT_W-1){1'b0}}, a > b};
      (opc == OP_EQ):  alu_res = {{(OUT_W-1){1'b0}}, a == b};
      (opc == OP_MAX): alu_res = (a > b) ? ae : be;
      (opc == OP_MIN): alu_res = (a < b) ? ae : be;
      default:         alu_res = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    mul_start = 1'b0;
    res_load  = 1'b0;
    res_nxt   = alu_res;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (opc == OP_MUL) begin
            mul_start = 1'b1;
            state_n   = MUL;
          end else begin
            res_load  = 1'b1;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          res_load = 1'b1;
          res_nxt  = mul_p;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c         <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= res_load;
      if (res_load) begin
        c    <= res_nxt;
        zero <= (res_nxt == '0);
      end
    end
  end

endmodule

// File: tb/tb_example_alu_seq.sv
// Directed self-checking bench for example_alu_seq at WIDTH=4 and WIDTH=8.
// Immediate assertions count failures; one summary line at the end.
module tb_example_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [2:0] opc;
  logic [3:0] a, b;
  logic [7:0] c;
  logic       zero, out_valid;

  logic        in_valid8, in_ready8;
  logic [2:0]  opc8;
  logic [7:0]  a8, b8;
  logic [15:0] c8;
  logic        zero8, out_valid8;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  example_alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opc(opc), .a(a), .b(b), .c(c), .zero(zero), .out_valid(out_valid)
  );

  example_alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .opc(opc8), .a(a8), .b(b8), .c(c8), .zero(zero8),
    .out_valid(out_valid8)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] t_opc [15];
  logic [3:0] t_a   [15];
  logic [3:0] t_b   [15];
  logic [7:0] t_c   [15];

  initial begin
    t_opc = '{0,0,0, 1,1,1, 3,3,3, 4,4,4, 5,5,5};
    t_a   = '{1,0,1, 1,0,1, 1,0,1, 1,0,1, 1,0,1};
    t_b   = '{0,1,1, 0,1,1, 0,1,1, 0,1,1, 0,1,1};
    t_c   = '{8'h01,8'h01,8'h02, 8'h01,8'hFF,8'h00,
              8'h00,8'h01,8'h00, 8'h01,8'h00,8'h00,
              8'h00,8'h00,8'h01};

    rst = 1'b1; in_valid = 1'b0; opc = 3'd0; a = 4'd0; b = 4'd0;
    in_valid8 = 1'b0; opc8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
    step(); step();
    chk("rst_c", 16'(c), 16'h00);
    chk("rst_zero", 16'(zero), 16'h1);
    chk("rst_ov", 16'(out_valid), 16'h0);
    chk("rst_rdy", 16'(in_ready), 16'h1);
    rst = 1'b0;
    step();
    chk("post_rst_c", 16'(c), 16'h00);
    chk("post_rst_ov", 16'(out_valid), 16'h0);

    // back-to-back single-cycle ops
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; opc = t_opc[i]; a = t_a[i]; b = t_b[i];
      step();
      chk($sformatf("b2b_c[%0d]", i), 16'(c), 16'(t_c[i]));
      chk($sformatf("b2b_z[%0d]", i), 16'(zero), 16'(t_c[i] == 8'h00));
      chk($sformatf("b2b_ov[%0d]", i), 16'(out_valid), 16'h1);
    end
    in_valid = 1'b0;
    step();
    chk("idle_ov", 16'(out_valid), 16'h0);
    chk("hold_c", 16'(c), 16'h01);

    // MUL 15*15
    in_valid = 1'b1; opc = 3'd2; a = 4'd15; b = 4'd15;
    step();
    in_valid = 1'b0;
    chk("m15_rdy1", 16'(in_ready), 16'h0);
    chk("m15_ov1", 16'(out_valid), 16'h0);
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("m15_rdy%0d", i), 16'(in_ready), 16'h0);
      chk($sformatf("m15_ov%0d", i), 16'(out_valid), 16'h0);
    end
    step();
    chk("m15_c", 16'(c), 16'hE1);
    chk("m15_z", 16'(zero), 16'h0);
    chk("m15_ov5", 16'(out_valid), 16'h1);
    chk("m15_rdy5", 16'(in_ready), 16'h1);
    step();
    chk("m15_ov6", 16'(out_valid), 16'h0);
    chk("m15_hold", 16'(c), 16'hE1);

    // MUL 0*7
    in_valid = 1'b1; opc = 3'd2; a = 4'd0; b = 4'd7;
    step();
    in_valid = 1'b0;
    for (int i = 2; i <= 4; i++) step();
    chk("m0_ov4", 16'(out_valid), 16'h0);
    step();
    chk("m0_c", 16'(c), 16'h00);
    chk("m0_z", 16'(zero), 16'h1);
    chk("m0_ov", 16'(out_valid), 16'h1);

    // request held during MUL
    in_valid = 1'b1; opc = 3'd2; a = 4'd3; b = 4'd5;
    step();
    opc = 3'd0; a = 4'd2; b = 4'd2;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("hs_ov%0d", i), 16'(out_valid), 16'h0);
    end
    step();
    chk("hs_mul_c", 16'(c), 16'h0F);
    chk("hs_mul_ov", 16'(out_valid), 16'h1);
    chk("hs_rdy", 16'(in_ready), 16'h1);
    step();
    chk("hs_add_c", 16'(c), 16'h04);
    chk("hs_add_ov", 16'(out_valid), 16'h1);
    in_valid = 1'b0;
    step();
    chk("hs_ov_end", 16'(out_valid), 16'h0);

    // reset mid-MUL
    in_valid = 1'b1; opc = 3'd2; a = 4'd9; b = 4'd9;
    step();
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_c", 16'(c), 16'h00);
    chk("rm_z", 16'(zero), 16'h1);
    chk("rm_ov", 16'(out_valid), 16'h0);
    chk("rm_rdy", 16'(in_ready), 16'h1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        seen = seen | out_valid;
      end
      chk("rm_no_ov", 16'(seen), 16'h0);
    end
    in_valid = 1'b1; opc = 3'd0; a = 4'd3; b = 4'd4;
    step();
    in_valid = 1'b0;
    chk("rm_add_c", 16'(c), 16'h07);
    chk("rm_add_ov", 16'(out_valid), 16'h1);

    // reset beats a simultaneous request
    rst = 1'b1; in_valid = 1'b1; opc = 3'd0; a = 4'd5; b = 4'd5;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rv_c", 16'(c), 16'h00);
    chk("rv_ov", 16'(out_valid), 16'h0);
    step();
    chk("rv_ov2", 16'(out_valid), 16'h0);

    // WIDTH=8 instance
    in_valid8 = 1'b1; opc8 = 3'd2; a8 = 8'd255; b8 = 8'd255;
    step();
    in_valid8 = 1'b0;
    chk("w8_rdy1", 16'(in_ready8), 16'h0);
    for (int i = 2; i <= 8; i++) step();
    chk("w8_ov8", 16'(out_valid8), 16'h0);
    step();
    chk("w8_mul_c", c8, 16'hFE01);
    chk("w8_mul_ov", 16'(out_valid8), 16'h1);
    in_valid8 = 1'b1; opc8 = 3'd6; a8 = 8'd200; b8 = 8'd17;
    step();
    chk("w8_max", c8, 16'h00C8);
    opc8 = 3'd7;
    step();
    chk("w8_min", c8, 16'h0011);
    opc8 = 3'd1; a8 = 8'd0; b8 = 8'd1;
    step();
    chk("w8_sub", c8, 16'hFFFF);
    chk("w8_sub_z", 16'(zero8), 16'h0);
    in_valid8 = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/example_alu_seq.md
Name: example_alu_seq

Overview:
- Parametrised, registered successor to the team's 3-bit-opcode example ALU/comparator.
- Operand width is generic. Adds a valid/ready input handshake, registered outputs with an output-valid strobe, a zero flag, and an iterative multi-cycle multiplier.
- Serves as a teaching and reference datapath block driven by a simple requester; all arithmetic is unsigned.

Parameters:
- WIDTH, 4, operand width in bits (must be 2 or greater).
- OUT_W, 2*WIDTH, result width; fixed at 2*WIDTH, not overridable.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  requester presents opc/a/b.
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge.
- opc  in  3  operation select.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- c  out  OUT_W  registered result.
- zero  out  1  registered; 1 when c == 0.
- out_valid  out  1  one-cycle strobe, high while c/zero carry a new result.

Behaviour:
- Clock/reset: one clock (clk). Reset is synchronous and active-high on rst.
- Reset values: c = 0, zero = 1, out_valid = 0, in_ready = 1, state = IDLE, multiplier registers cleared.
- Opcodes:
  - 0 ADD: c = a + b.
  - 1 SUB: c = a − b, computed mod 2^OUT_W (0−1 gives all ones).
  - 2 MUL: c = a*b.
  - 3 LT: c = (a < b).
  - 4 GT: c = (a > b).
  - 5 EQ: c = (a == b).
  - 6 MAX: c = max(a, b).
  - 7 MIN: c = min(a, b).
  - Operands are zero-extended to OUT_W. Compare results occupy bit 0; upper bits are 0.
- States:
  - IDLE: in_ready = 1.
  - MUL: in_ready = 0.
- IDLE, opcode ≠ 2, on accept:
  - c, zero and out_valid = 1 update on the same accepting edge (latency 1).
  - Stays in IDLE, so back-to-back accepts every cycle are allowed.
- IDLE, opcode 2, on accept:
  - Load mcand = zero-extended a, mplier = b, prod = 0, cnt = WIDTH; go to MUL.
  - out_valid = 0 on that edge.
- MUL, each cycle:
  - If mplier[0], prod += mcand; then mcand <<= 1, mplier >>= 1, cnt −= 1.
  - On the edge where cnt goes 1→0: c = final prod, zero updated, out_valid = 1, return to IDLE.
  - Total latency is WIDTH+1 edges from the accepting edge; in_ready reasserts in the same cycle out_valid is high.
- Product width: the product never exceeds OUT_W, so there is no overflow. ADD carry lands in bit WIDTH.
- out_valid: high for exactly one cycle per accepted operation; there is no output backpressure.
- Holding: c and zero hold their last value between results. in_valid without in_ready is ignored, with no side effects.
- Input changes: changes on opc/a/b during MUL do not affect the in-flight product.
- Reset during MUL: aborts the operation; the reset values apply on that edge and no out_valid is produced for the aborted operation.
- Simultaneous rst and in_valid: reset wins; the request is dropped.

Decomposition:
- Package example_alu_pkg:
  - Opcode localparams OP_ADD … OP_MIN (3 bits).
  - State encoding IDLE/MUL.
- One sub-module: example_shift_mul (WIDTH parameter).
  - Inputs: start, a, b.
  - Outputs: done strobe, product.
  - Owns mcand/mplier/prod/cnt.
- The top holds the handshake, opcode decode, result register and zero flag.

Test Plan:
- WIDTH=4, reset: rst high for 2 cycles → c=0x00, zero=1, out_valid=0, in_ready=1; after release, c unchanged until the first accept.
- Back-to-back single-cycle ops: opc 0/1/3/4/5 with (a,b)=(1,0),(0,1),(1,1) every cycle → ADD 01,01,02; SUB 01,FF,00 (zero=1 on 00); LT 0,1,0; GT 1,0,0; EQ 0,0,1; out_valid high each following cycle.
- MUL 15*15: accept, then in_ready=0 for 4 cycles → c=0xE1 and out_valid at edge 5 only. MUL 0*7 → c=0x00, zero=1 at edge 5.
- Handshake during MUL: hold in_valid with opc=0 throughout → no extra out_valid while busy; the request is accepted on the cycle in_ready returns.
- Reset mid-MUL: start 9*9, assert rst at edge 2 → no out_valid ever for it, c=0, in_ready=1; a following ADD 3+4 returns c=0x07.
- Parametric: WIDTH=8, MUL 255*255 → c=0xFE01 after 9 edges; MAX(200,17)=200; SUB 0−1=0xFFFF.
